// File: rtl/drum_hit_scheduler.sv
// drum_hit_scheduler: shares one sample-player / sprite-highlight slot among
// NUM_PADS drum pads. Rising hit edges are latched into `pending`, served
// round-robin over a valid/ready offer, then the winner is held on `selected`
// for HOLD_FRAMES video frames followed by COOLDOWN_CYCLES idle clocks.
// Optional feature macro: RETRIGGER_EN (a new edge on the held pad during
// HOLD restarts the hold instead of queueing).
module drum_hit_scheduler #(
  parameter int NUM_PADS        = 14,
  parameter int HOLD_FRAMES     = 8,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_PADS-1:0] hit,
  input  logic                frame_tick,
  input  logic                play_ready,
  output logic                play_valid,
  output logic [3:0]          play_idx,
  output logic [3:0]          selected,
  output logic                active,
  output logic [NUM_PADS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, OFFER, HOLD, COOLDOWN} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);
  localparam logic [7:0] CD_INIT   = 8'(COOLDOWN_CYCLES);
  localparam logic [3:0] LAST_INIT = 4'(NUM_PADS - 1);

  state_t              state;
  logic [NUM_PADS-1:0] hit_prev;
  logic [NUM_PADS-1:0] rise;
  logic [NUM_PADS-1:0] clr_mask;
  logic [NUM_PADS-1:0] retrig_mask;
  logic [NUM_PADS-1:0] set_mask;
  logic                retrig;
  logic                accept;
  logic [3:0]          last;
  logic [3:0]          winner;
  logic                found;
  int                  pos;
  logic [7:0]          hold_cnt;
  logic [7:0]          cd_cnt;

  assign rise   = hit & ~hit_prev;
  assign accept = (state == OFFER) && play_ready;

  // Clear mask for the accepted pad (play_idx is the registered winner, so a
  // late edge on an earlier pad cannot redirect the clear) and retrigger mask.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask = NUM_PADS'(1) << (play_idx - 4'd1);
`ifdef RETRIGGER_EN
    retrig_mask = '0;
    if (state == HOLD && selected != 4'd0)
      retrig_mask = NUM_PADS'(1) << (selected - 4'd1);
`else
    retrig_mask = '0;
`endif
    retrig   = |(rise & retrig_mask);
    set_mask = rise & ~retrig_mask;
  end

  // Round-robin search: first pending bit above `last`, wrapping to bit 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_PADS; k++) begin
      pos = (int'(last) + 1 + k) % NUM_PADS;
      if (!found && pending[pos]) begin
        winner = 4'(pos);
        found  = 1'b1;
      end
    end
  end

  // Edge capture: runs in every state; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_prev <= '0;
      pending  <= '0;
    end else begin
      hit_prev <= hit;
      pending  <= (pending & ~clr_mask) | set_mask;
    end
  end

  // Offer / hold / cooldown sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      play_valid <= 1'b0;
      play_idx   <= '0;
      selected   <= '0;
      active     <= 1'b0;
      last       <= LAST_INIT;
      hold_cnt   <= '0;
      cd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          play_valid <= 1'b0;
          if (pending != '0) begin
            play_idx   <= winner + 4'd1;
            play_valid <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (play_ready) begin
            last       <= play_idx - 4'd1;
            selected   <= play_idx;
            active     <= 1'b1;
            play_valid <= 1'b0;
            hold_cnt   <= HOLD_INIT;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (retrig) begin
            hold_cnt <= HOLD_INIT;
          end else if (frame_tick) begin
            if (hold_cnt == 8'd1) begin
              selected <= '0;
              active   <= 1'b0;
              hold_cnt <= '0;
              if (COOLDOWN_CYCLES == 0) begin
                state <= IDLE;
              end else begin
                cd_cnt <= CD_INIT;
                state  <= COOLDOWN;
              end
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
            end
          end
        end
        COOLDOWN: begin
          cd_cnt <= cd_cnt - 8'd1;
          if (cd_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_hit_scheduler.sv
// Directed testbench for drum_hit_scheduler (NUM_PADS=14, HOLD_FRAMES=8,
// COOLDOWN_CYCLES=4). Expected values are hand-derived constants.
module tb_drum_hit_scheduler;

  logic        clk;
  logic        reset_n;
  logic [13:0] hit;
  logic        frame_tick;
  logic        play_ready;
  logic        play_valid;
  logic [3:0]  play_idx;
  logic [3:0]  selected;
  logic        active;
  logic [13:0] pending;

  int checks = 0;
  int errors = 0;

  drum_hit_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hit        (hit),
    .frame_tick (frame_tick),
    .play_ready (play_ready),
    .play_valid (play_valid),
    .play_idx   (play_idx),
    .selected   (selected),
    .active     (active),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_hit(input logic [13:0] mask);
    hit = mask;
    step();
    hit = '0;
  endtask

  // Full hold (8 frames) plus 4 cooldown clocks; block is IDLE afterwards.
  task automatic hold_out();
    for (int i = 0; i < 8; i++) frame();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    hit        = '0;
    frame_tick = 1'b0;
    play_ready = 1'b1;
    step();
    step();
    check("rst_valid",    32'(play_valid), 32'd0);
    check("rst_idx",      32'(play_idx),   32'd0);
    check("rst_selected", 32'(selected),   32'd0);
    check("rst_active",   32'(active),     32'd0);
    check("rst_pending",  32'(pending),    32'd0);
    reset_n = 1'b1;
    step();

    // ---- single pad 0 hit ----
    pulse_hit(14'h0001);
    check("t1_latched", 32'(pending), 32'h1);
    check("t1_novalid", 32'(play_valid), 32'd0);
    step();
    check("t1_offer", 32'({play_valid, play_idx}), 32'h11);
    step();
    check("t1_accept", 32'({play_valid, active, selected}), 32'h11);
    check("t1_pend_clr", 32'(pending), 32'h0);
    for (int i = 0; i < 7; i++) frame();
    check("t1_hold7", 32'({active, selected}), 32'h11);
    frame();
    check("t1_hold_end", 32'({active, selected}), 32'h00);
    pulse_hit(14'h0002);
    step();
    step();
    step();
    check("t1_cooldown", 32'(play_valid), 32'd0);
    step();
    check("t1_next_offer", 32'({play_valid, play_idx}), 32'h12);
    step();
    check("t1_next_sel", 32'(selected), 32'd2);
    hold_out();

    // ---- all 14 pads at once, served 1..14 ----
    do_reset();
    step();
    pulse_hit(14'h3FFF);
    check("t2_pending_all", 32'(pending), 32'h3FFF);
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("t2_offer%0d", k), 32'({play_valid, play_idx}), 32'h10 | 32'(k));
      step();
      check($sformatf("t2_sel%0d", k), 32'(selected), 32'(k));
      check($sformatf("t2_pend%0d", k), 32'(pending), 32'h3FFF & ~((32'd1 << k) - 32'd1));
      hold_out();
    end
    check("t2_drained", 32'(pending), 32'h0);

    // ---- round-robin wrap ----
    do_reset();
    step();
    pulse_hit(14'h0004);
    step();
    check("t3_offer3", 32'(play_idx), 32'd3);
    step();
    hold_out();
    pulse_hit(14'h2001);
    step();
    check("t3_offer14", 32'({play_valid, play_idx}), 32'h1E);
    step();
    hold_out();
    step();
    check("t3_offer1", 32'({play_valid, play_idx}), 32'h11);
    step();
    check("t3_sel1", 32'(selected), 32'd1);
    hold_out();

    // ---- stalled offer, late edge on an earlier pad ----
    play_ready = 1'b0;
    pulse_hit(14'h0040);
    step();
    for (int i = 0; i < 20; i++) begin
      if (i == 9) hit = 14'h0020;
      step();
      hit = '0;
      check($sformatf("t4_stall%0d", i), 32'({play_valid, play_idx}), 32'h17);
    end
    check("t4_pending", 32'(pending), 32'h0060);
    play_ready = 1'b1;
    step();
    check("t4_sel7", 32'({active, selected}), 32'h17);
    check("t4_pend5", 32'(pending), 32'h0020);

    // ---- asynchronous reset during hold ----
    frame();
    frame();
    reset_n = 1'b0;
    #1;
    check("t6_async", 32'({play_valid, active, selected, pending}), 32'h0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t6_idle", 32'({play_valid, active, pending}), 32'h0);

    // ---- edge in the accept cycle, then mid-hold edge on held pad ----
    pulse_hit(14'h0010);
    step();
    check("t5_offer5", 32'({play_valid, play_idx}), 32'h15);
    hit = 14'h0010;
    step();
    hit = '0;
    check("t5_sel5", 32'(selected), 32'd5);
    check("t5_pend_kept", 32'(pending), 32'h0010);
    hold_out();
    step();
    check("t5_reserve", 32'({play_valid, play_idx}), 32'h15);
    step();
    check("t5_pend_clr", 32'(pending), 32'h0);
    for (int i = 0; i < 3; i++) frame();
    pulse_hit(14'h0010);
`ifdef RETRIGGER_EN
    check("t5_retrig_pend", 32'(pending), 32'h0);
    for (int i = 0; i < 7; i++) frame();
    check("t5_retrig_hold", 32'({active, selected}), 32'h15);
    frame();
    check("t5_retrig_end", 32'({active, selected}), 32'h00);
`else
    check("t5_queue_pend", 32'(pending), 32'h0010);
    for (int i = 0; i < 4; i++) frame();
    check("t5_queue_hold", 32'({active, selected}), 32'h15);
    frame();
    check("t5_queue_end", 32'({active, selected}), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
